ret_addr_stack: RTL and testbench
=================================

# ret_addr_stack

Return-address stack for the 16-bit core. It writes link addresses on call-type jumps (JAL) and supplies them back for jump-register returns, producing the 13-bit target that the PC source select consumes as its register-side return address. It sits beside the program counter and is updated once per cycle from decode-stage call/return strobes. Overflow and underflow are reported, never silently masked.

## Interface
- DEPTH, 8, number of stack entries; power of two, minimum 2
- AW, 3, pointer width; must equal log2(DEPTH)

- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  high: call/ret ignored this cycle, state held
- call  input  1  push strobe (JAL decoded)
- ret  input  1  pop strobe (JR decoded)
- call_pc  input  13  address of the call instruction
- ret_addr  output  13  current top-of-stack return address; 0 when empty
- ret_valid  output  1  high when count > 0
- full  output  1  high when count == DEPTH
- count  output  AW+1  number of valid entries, 0..DEPTH
- overflow  output  1  sticky: a push occurred while full
- underflow  output  1  sticky: a pop occurred while empty

## Operation
- Storage: circular buffer of DEPTH × 13-bit entries, write pointer wp (AW bits, index of next free slot), count (AW+1 bits).
- Top index = (wp − 1) mod DEPTH; wrap-around is native AW-bit arithmetic.
- Pushed value = (call_pc + 1) mod 2^13; 13'h1FFF pushes 13'h0000.
- Action per cycle, evaluated only when stall = 0:
  - call only, count < DEPTH: write entry[wp], wp+1, count+1.
  - call only, count == DEPTH: write entry[wp] (overwrites oldest), wp+1, count unchanged, overflow ← 1.
  - ret only, count > 0: wp−1, count−1; entry contents untouched.
  - ret only, count == 0: no pointer/count change, underflow ← 1.
  - call and ret, count > 0: replace top in place (entry[wp−1] ← new value), wp and count unchanged.
  - call and ret, count == 0: behaves as push (count → 1), underflow ← 1.
  - neither: hold.
- stall = 1: all state held regardless of call/ret; flags not set.
- ret_addr = entry[top] when count > 0, else 13'h0000 (combinational from registered state).
- ret_valid = (count != 0); full = (count == DEPTH).
- overflow/underflow clear only on rst.

## Timing
- Reset (asynchronous assert, takes effect immediately): wp = 0, count = 0, overflow = 0, underflow = 0; therefore ret_addr = 0, ret_valid = 0, full = 0. Entry array is not reset; its contents are unobservable while empty.
- Reset release: first state update on the first rising edge with rst low.
- Reset asserted mid-operation: stack emptied at once; any in-flight call/ret that cycle is discarded.
- Push at edge N: new value on ret_addr and updated count/full after edge N (visible in cycle N+1). No same-cycle bypass: ret in the same cycle as a call sees the pre-edge top (the replace rule above).
- Pop at edge N: ret_addr shows the next-older entry from cycle N+1. The consumer samples ret_addr in the cycle it asserts ret.
- Flags rise on the edge of the offending operation and remain high.
- Single-cycle throughput: one operation per cycle, no internal bubbles.

## Test plan
- Reset then idle: rst pulse mid-cycle -> ret_addr = 0, ret_valid = 0, count = 0, flags 0 immediately, before any clock edge.
- Push/pop order: call with call_pc = 0x010, 0x020, 0x030 -> ret_addr 0x011, 0x021, 0x031 in turn; three rets -> 0x031, 0x021, 0x011, then ret_valid = 0, ret_addr = 0.
- Overflow wrap (DEPTH = 8): push call_pc 0..8 (nine calls) -> full = 1, count = 8, overflow = 1; eight pops return 9, 8, …, 2; value 1 is lost.
- Underflow and simultaneous: ret on empty -> underflow = 1, count = 0; with count = 2 and top 0x051, call (call_pc = 0x100) + ret together -> count stays 2, ret_addr = 0x101.
- Stall and wrap edge: call_pc = 0x1FFF with stall = 1 -> no change; stall = 0 -> ret_addr = 0x0000, ret_valid = 1.
- Reset mid-stream: 4 entries pushed, rst asserted concurrent with a call -> count = 0, ret_valid = 0; the next push after release lands at count = 1.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular buffer of link addresses pushed on calls, popped on returns.
// Latency: push/pop visible on ret_addr/count the cycle after the edge; outputs combinational from state.
// Backpressure: stall holds all state; overflow overwrites oldest, underflow is ignored, both reported sticky.
module ret_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          call,
    input  logic          ret,
    input  logic [12:0]   call_pc,
    output logic [12:0]   ret_addr,
    output logic          ret_valid,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] top;
    logic [12:0]   push_val;
    logic          empty;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] wp_nxt;
    logic [AW:0]   count_nxt;
    logic          ovf_set;
    logic          unf_set;

    assign top      = wp - 1'b1;
    assign push_val = call_pc + 13'd1;
    assign empty    = (count == '0);

    // Decode this cycle's action into write, pointer, count and flag updates.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = wp;
        wp_nxt    = wp;
        count_nxt = count;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (!stall) begin
            if (call && !ret) begin
                wr_en  = 1'b1;
                wp_nxt = wp + 1'b1;
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else if (ret && !call) begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    wp_nxt    = wp - 1'b1;
                    count_nxt = count - 1'b1;
                end
            end else if (call && ret) begin
                wr_en = 1'b1;
                if (empty) begin
                    // Nothing to return from: act as a plain push and flag it.
                    wp_nxt    = wp + 1'b1;
                    count_nxt = count + 1'b1;
                    unf_set   = 1'b1;
                end else begin
                    // Return then call collapses to rewriting the top entry.
                    wr_idx = top;
                end
            end
        end
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp        <= wp_nxt;
            count     <= count_nxt;
            overflow  <= overflow | ovf_set;
            underflow <= underflow | unf_set;
        end
    end

    // Entry storage is not reset; contents are unobservable while empty.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= push_val;
        end
    end

    // Top-of-stack view for the PC select.
    always_comb begin
        ret_addr = 13'h0000;
        if (!empty) begin
            ret_addr = mem[top];
        end
    end

    assign ret_valid = !empty;
    assign full      = (count == FULL_CNT);

endmodule

// File: tb/tb_ret_addr_stack.sv
module tb_ret_addr_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [12:0]   call_pc = '0;
    logic [12:0]   ret_addr;
    logic          ret_valid;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of live return addresses, oldest first.
    logic [12:0] mdl[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [20:0] exp_q[$];

    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .call(call), .ret(ret),
        .call_pc(call_pc), .ret_addr(ret_addr), .ret_valid(ret_valid),
        .full(full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] model_vec();
        logic [12:0] top;
        top = (mdl.size() > 0) ? mdl[mdl.size()-1] : 13'h0000;
        return {top, mdl.size() > 0, mdl.size() == DEPTH, 4'(mdl.size()), m_ovf, m_unf};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {ret_addr, ret_valid, full, count, overflow, underflow};
    endfunction

    task automatic model_apply(input logic c, input logic r, input logic s, input logic [12:0] pc);
        logic [12:0] v;
        v = pc + 13'd1;
        if (!s) begin
            if (c && !r) begin
                if (mdl.size() == DEPTH) begin
                    void'(mdl.pop_front());
                    m_ovf = 1'b1;
                end
                mdl.push_back(v);
            end else if (r && !c) begin
                if (mdl.size() > 0) void'(mdl.pop_back());
                else m_unf = 1'b1;
            end else if (c && r) begin
                if (mdl.size() > 0) mdl[mdl.size()-1] = v;
                else begin
                    mdl.push_back(v);
                    m_unf = 1'b1;
                end
            end
        end
    endtask

    // One operation: drive at negedge, record the expected post-edge state.
    task automatic step(input logic c, input logic r, input logic s, input logic [12:0] pc);
        @(negedge clk);
        call = c; ret = r; stall = s; call_pc = pc;
        model_apply(c, r, s, pc);
        exp_q.push_back(model_vec());
        @(posedge clk);
    endtask

    // Mid-cycle reset pulse, optionally with a call in flight that must be discarded.
    task automatic reset_pulse(input logic c, input logic [12:0] pc);
        @(negedge clk);
        call = c; ret = 1'b0; stall = 1'b0; call_pc = pc;
        #2 rst = 1'b1;
        #1;
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("reset_state", 32'(dut_vec()), 32'(model_vec()));
        chk("reset_count", 32'(count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; call = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge.
    initial begin
        logic [20:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scoreboard", 32'(dut_vec()), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic c, r, s;
        reset_pulse(1'b0, 13'h0);
        chk("idle_ret_addr", 32'(ret_addr), 32'h0);

        // Push/pop order.
        step(1, 0, 0, 13'h010);
        step(1, 0, 0, 13'h020);
        step(1, 0, 0, 13'h030);
        #1 chk("lifo_top", 32'(ret_addr), 32'h031);
        step(0, 1, 0, 13'h0);
        #1 chk("lifo_pop1", 32'(ret_addr), 32'h021);
        step(0, 1, 0, 13'h0);
        #1 chk("lifo_pop2", 32'(ret_addr), 32'h011);
        step(0, 1, 0, 13'h0);
        #1 chk("lifo_empty", 32'({ret_valid, ret_addr}), 32'h0);

        // Overflow wrap: nine pushes, eight pops return 9..2.
        reset_pulse(1'b0, 13'h0);
        for (int i = 0; i <= 8; i++) step(1, 0, 0, 13'(i));
        #1 chk("ovf_flags", 32'({full, count, overflow}), {27'd0, 1'b1, 4'd8, 1'b1});
        for (int i = 0; i < 8; i++) begin
            chk("ovf_pop_val", 32'(ret_addr), 32'(9 - i));
            step(0, 1, 0, 13'h0);
            #1;
        end
        chk("ovf_drained", 32'(ret_valid), 32'd0);

        // Underflow and simultaneous call+ret.
        reset_pulse(1'b0, 13'h0);
        step(0, 1, 0, 13'h0);
        #1 chk("unf_flag", 32'({underflow, count}), {27'd0, 1'b1, 4'd0});
        step(1, 0, 0, 13'h040);
        step(1, 0, 0, 13'h050);
        #1 chk("pre_swap_top", 32'(ret_addr), 32'h051);
        step(1, 1, 0, 13'h100);
        #1 chk("swap", 32'({count, ret_addr}), {15'd0, 4'd2, 13'h101});

        // Stall and 13-bit wrap.
        reset_pulse(1'b0, 13'h0);
        step(1, 0, 1, 13'h1FFF);
        #1 chk("stall_hold", 32'({ret_valid, count}), 32'd0);
        step(1, 0, 0, 13'h1FFF);
        #1 chk("pc_wrap", 32'({ret_valid, ret_addr}), {18'd0, 1'b1, 13'h0000});

        // Reset in the middle of a stream, concurrent with a call.
        reset_pulse(1'b0, 13'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 13'(12'h200 + i));
        reset_pulse(1'b1, 13'h0AA);
        chk("mid_reset_valid", 32'(ret_valid), 32'd0);
        step(1, 0, 0, 13'h300);
        #1 chk("post_reset_push", 32'({count, ret_addr}), {15'd0, 4'd1, 13'h301});

        // Randomized traffic: push-heavy then pop-heavy phases.
        reset_pulse(1'b0, 13'h0);
        for (int i = 0; i < 600; i++) begin
            int pc_bias;
            pc_bias = ((i / 100) % 2 == 0) ? 70 : 30;
            c = ($urandom_range(0, 99) < pc_bias);
            r = ($urandom_range(0, 99) < (100 - pc_bias));
            s = ($urandom_range(0, 9) == 0);
            step(c, r, s, 13'($urandom));
        end

        @(negedge clk);
        call = 1'b0; ret = 1'b0; stall = 1'b0;
        @(posedge clk);
        #2 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
